// File: rtl/mem_latency_model.sv
// rtl/mem_latency_model.sv - latency-configurable synchronous memory model with storage
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req          access strobe (TRIG_MODE=0)
//   memory_w     1 = write, 0 = read, sampled with the trigger
//   addr         word address, sampled with the trigger
//   wdata        write data, sampled with the trigger
//   rdata        read data, updated when a read completes
//   memory_ready 1 = idle / access complete, 0 = access in progress
//   error        last completed access was out of range
module mem_latency_model #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int RD_LAT     = 1,
    parameter int WR_LAT     = 2,
    parameter int TRIG_MODE  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              memory_w,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              memory_ready,
    output logic              error
);

    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    // The counter only ever holds LAT-1, so clog2(MAX_LAT) bits suffice.
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int DEPTH   = 2 ** DEPTH_LOG2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                error_q, error_d;

    // Storage is deliberately outside the reset domain: reset aborts accesses
    // but never disturbs contents.
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                trig;
    logic                in_range;
    logic                complete;

    // Legacy mode fires on any address change relative to the last accepted one.
    assign trig     = (TRIG_MODE == 0) ? req : (addr != last_addr_q);
    assign in_range = ((addr_q >> DEPTH_LOG2) == '0);
    assign complete = (state_q == BUSY) && (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        rdata_d     = rdata_q;
        error_d     = error_q;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    addr_d      = addr;
                    last_addr_d = addr;
                    wdata_d     = wdata;
                    we_d        = memory_w;
                    cnt_d       = memory_w ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    error_d = !in_range;
                    if (!we_q) begin
                        rdata_d = in_range ? mem_q[addr_q[DEPTH_LOG2-1:0]] : '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            last_addr_q <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
        end
    end

    // Out-of-range writes are dropped; a reset forces IDLE so no commit occurs.
    always_ff @(posedge clk) begin
        if (complete && we_q && in_range) begin
            mem_q[addr_q[DEPTH_LOG2-1:0]] <= wdata_q;
        end
    end

    assign memory_ready = (state_q == IDLE);
    assign rdata        = rdata_q;
    assign error        = error_q;

endmodule

// File: tb/tb_mem_latency_model.sv
// tb/tb_mem_latency_model.sv - self-checking bench for mem_latency_model
module tb_mem_latency_model;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_s   [3];
    logic        mw_s    [3];
    logic [15:0] addr_s  [3];
    logic [15:0] wdata_s [3];
    logic [15:0] rdata_s [3];
    logic        rdy_s   [3];
    logic        err_s   [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // d0: defaults, d1: RD_LAT=4 WR_LAT=3, d2: legacy address-change trigger
    mem_latency_model dut0 (
        .clk(clk), .rst_n(rst_n), .req(req_s[0]), .memory_w(mw_s[0]),
        .addr(addr_s[0]), .wdata(wdata_s[0]), .rdata(rdata_s[0]),
        .memory_ready(rdy_s[0]), .error(err_s[0])
    );
    mem_latency_model #(.RD_LAT(4), .WR_LAT(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req_s[1]), .memory_w(mw_s[1]),
        .addr(addr_s[1]), .wdata(wdata_s[1]), .rdata(rdata_s[1]),
        .memory_ready(rdy_s[1]), .error(err_s[1])
    );
    mem_latency_model #(.TRIG_MODE(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req_s[2]), .memory_w(mw_s[2]),
        .addr(addr_s[2]), .wdata(wdata_s[2]), .rdata(rdata_s[2]),
        .memory_ready(rdy_s[2]), .error(err_s[2])
    );

    typedef struct {
        int          d;
        logic        we;
        logic [15:0] a;
        logic [15:0] wd;
        logic [15:0] exp_rd;
        logic        exp_err;
        int          lat;
    } vec_t;

    typedef struct {
        int          d;
        logic [15:0] rd;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one request-strobe access, then measure ready-low cycles and
    // compare against the expectation queued when it was driven.
    task automatic issue(input vec_t v, input string name);
        exp_t e;
        int   n;
        bit   done;
        @(posedge clk); #1;
        req_s[v.d]   = 1'b1;
        mw_s[v.d]    = v.we;
        addr_s[v.d]  = v.a;
        wdata_s[v.d] = v.wd;
        sbq.push_back('{d: v.d, rd: v.exp_rd, err: v.exp_err, lat: v.lat});
        @(posedge clk); #1;
        req_s[v.d] = 1'b0;
        n    = 0;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (rdy_s[v.d]) done = 1'b1;
            else n++;
        end
        e = sbq.pop_front();
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: ready never rose, required within 50 cycles", name);
        end
        check({name, " latency"}, n, e.lat);
        check({name, " rdata"}, rdata_s[e.d], e.rd);
        check({name, " error"}, err_s[e.d], e.err);
    endtask

    // Compare memory_ready against a bit pattern over n successive negedges.
    task automatic watch(input int d, input string name, input int n, input logic [15:0] pat);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s ready[%0d]", name, i), rdy_s[d], pat[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 2};
        tbl[1]  = '{0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1};
        tbl[2]  = '{0, 1'b1, 16'h0011, 16'h1234, 16'hBEEF, 1'b0, 2};
        tbl[3]  = '{0, 1'b1, 16'h0000, 16'h5A5A, 16'hBEEF, 1'b0, 2};
        tbl[4]  = '{0, 1'b1, 16'h0100, 16'hAAAA, 16'hBEEF, 1'b1, 2};
        tbl[5]  = '{0, 1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1, 1};
        tbl[6]  = '{0, 1'b0, 16'h0000, 16'h0000, 16'h5A5A, 1'b0, 1};
        tbl[7]  = '{0, 1'b1, 16'h00FF, 16'h0F0F, 16'h5A5A, 1'b0, 2};
        tbl[8]  = '{0, 1'b0, 16'h00FF, 16'h0000, 16'h0F0F, 1'b0, 1};
        tbl[9]  = '{0, 1'b0, 16'h8000, 16'h0000, 16'h0000, 1'b1, 1};
        tbl[10] = '{0, 1'b0, 16'h0011, 16'h0000, 16'h1234, 1'b0, 1};
        tbl[11] = '{1, 1'b1, 16'h0030, 16'hABCD, 16'h0000, 1'b0, 3};
        tbl[12] = '{1, 1'b0, 16'h0030, 16'h0000, 16'hABCD, 1'b0, 4};

        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            req_s[d] = 1'b0; mw_s[d] = 1'b0; addr_s[d] = '0; wdata_s[d] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset ready d%0d", d), rdy_s[d], 1'b1);
            check($sformatf("reset rdata d%0d", d), rdata_s[d], 16'h0000);
            check($sformatf("reset error d%0d", d), err_s[d], 1'b0);
        end
        rst_n = 1'b1;

        // Legacy mode: address still equals last_addr after reset, no access.
        watch(2, "trig1 idle", 3, 16'b111);

        for (int i = 0; i < 13; i++) begin
            issue(tbl[i], $sformatf("vec%0d", i));
        end

        // Back-to-back with req held: write (3) then read (4), one-cycle gap.
        @(posedge clk); #1;
        req_s[1] = 1'b1; mw_s[1] = 1'b1; addr_s[1] = 16'h0020; wdata_s[1] = 16'hCAFE;
        @(posedge clk); #1;
        mw_s[1] = 1'b0;
        wdata_s[1] = 16'h9999;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("b2b ready[%0d]", i), rdy_s[1], (i == 3) ? 1'b1 : 1'b0);
            if (i == 3) check("b2b rdata after write", rdata_s[1], 16'hABCD);
        end
        @(negedge clk);
        check("b2b ready[8]", rdy_s[1], 1'b1);
        check("b2b rdata after read", rdata_s[1], 16'hCAFE);
        req_s[1] = 1'b0;
        watch(1, "b2b released", 2, 16'b11);

        // Legacy mode: address change triggers, holding it does not.
        @(negedge clk);
        addr_s[2] = 16'h0005; mw_s[2] = 1'b1; wdata_s[2] = 16'h7777;
        watch(2, "trig1 write", 5, 16'b11100);
        check("trig1 write error", err_s[2], 1'b0);
        addr_s[2] = 16'h0006; mw_s[2] = 1'b1; wdata_s[2] = 16'h1111;
        watch(2, "trig1 write2", 3, 16'b100);
        addr_s[2] = 16'h0005; mw_s[2] = 1'b0;
        watch(2, "trig1 read", 3, 16'b110);
        check("trig1 read rdata", rdata_s[2], 16'h7777);

        // Reset after the first BUSY edge of a write aborts it.
        @(posedge clk); #1;
        req_s[0] = 1'b1; mw_s[0] = 1'b1; addr_s[0] = 16'h0010; wdata_s[0] = 16'h1111;
        @(posedge clk); #1;
        req_s[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid reset ready", rdy_s[0], 1'b1);
        check("mid reset rdata", rdata_s[0], 16'h0000);
        check("mid reset error", err_s[0], 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue('{0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1}, "post reset read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
